// File: rtl/hier_leaf_pkg.sv
// Shared constants and helpers for the hierarchy leaf FIFO.
//   LEAF_DATA_W : default payload width
//   LEAF_DEPTH  : default storage depth (power of two)
//   ptr_w()     : pointer width for a given depth
package hier_leaf_pkg;

  localparam int LEAF_DATA_W = 8;
  localparam int LEAF_DEPTH  = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hier_leaf_fifo_if.sv
// Valid/ready stream bundle used on both sides of the leaf FIFO.
//   valid : source presents data
//   ready : sink accepts this cycle
//   data  : payload
// master drives valid/data, slave drives ready.
interface hier_leaf_fifo_if
  import hier_leaf_pkg::*;
#(
  parameter int DATA_W = LEAF_DATA_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/hier_leaf_ptr.sv
// Wrapping pointer counter for the leaf FIFO.
//   clk : clock
//   rst : synchronous active-high reset to 0
//   clr : synchronous clear to 0 (flush)
//   inc : advance by one, wrapping at 2**W-1 -> 0
//   q   : current pointer value
module hier_leaf_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hier_leaf_fifo.sv
// First-word-fall-through FIFO decoupling two sibling leaf streams.
//   clk    : sole clock
//   rst    : synchronous active-high reset (wins over flush)
//   flush  : synchronous clear of pointers and occupancy
//   in_s   : producer stream (slave side: FIFO drives ready)
//   out_m  : consumer stream (master side: FIFO drives valid/data)
//   count  : occupancy 0..DEPTH
//   full   : count == DEPTH
//   empty  : count == 0
// in_ready depends only on registered state, so there is no combinational
// path from out_m.ready to in_s.ready.
module hier_leaf_fifo
  import hier_leaf_pkg::*;
#(
  parameter int DATA_W = LEAF_DATA_W,
  parameter int DEPTH  = LEAF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  hier_leaf_fifo_if.slave            in_s,
  hier_leaf_fifo_if.master           out_m,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     occ_diff;
  logic              rst_q;
  logic              clr;
  logic              push;
  logic              pop;

  assign clr   = rst || flush;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // rst_q keeps the producer out for one cycle after reset releases.
  assign in_s.ready  = !full && !rst_q;
  assign out_m.valid = !empty;
  assign out_m.data  = mem[rd_ptr];

  // Handshakes in a reset/flush cycle are discarded entirely.
  assign push = in_s.valid && in_s.ready && !clr;
  assign pop  = out_m.valid && out_m.ready && !clr;

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  hier_leaf_ptr #(.W(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .q   (wr_ptr)
  );

  hier_leaf_ptr #(.W(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .q   (rd_ptr)
  );

  // NOTE: storage has no reset; only pointers and count define validity,
  // so stale words are never observable while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_s.data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign occ_diff = wr_ptr - rd_ptr;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full)) else $error("push while full");

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty)) else $error("pop while empty");

  // Pointers alias when full, so full is checked by pointer equality.
  a_count_ptrs: assert property (@(posedge clk) disable iff (rst)
    full ? (wr_ptr == rd_ptr) : (count == CW'(occ_diff)))
    else $error("count inconsistent with pointers");

endmodule

// File: tb/tb_hier_leaf_fifo.sv
// Directed plus randomised self-checking bench for hier_leaf_fifo.
module tb_hier_leaf_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_pass   = 0;

  hier_leaf_fifo_if #(.DATA_W(DATA_W)) in_if ();
  hier_leaf_fifo_if #(.DATA_W(DATA_W)) out_if ();

  hier_leaf_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .in_s  (in_if),
    .out_m (out_if),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    in_if.valid = 1'b1;
    in_if.data  = d;
    tick();
    in_if.valid = 1'b0;
  endtask

  logic [7:0] model_q [$];

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    // Reset and idle.
    tick();
    tick();
    check("rst in_ready", in_if.ready, 0);
    check("rst out_valid", out_if.valid, 0);
    check("rst count", count, 0);
    check("rst full", full, 0);
    check("rst empty", empty, 1);
    rst = 1'b0;
    check("post-rst in_ready", in_if.ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle in_ready", in_if.ready, 1);
      check("idle empty", empty, 1);
      check("idle count", count, 0);
      check("idle out_valid", out_if.valid, 0);
    end

    // Fill to full with consumer stalled.
    push_one(8'h11);
    check("fill1 out_valid", out_if.valid, 1);
    check("fill1 head", out_if.data, 8'h11);
    push_one(8'h22);
    push_one(8'h33);
    push_one(8'h44);
    check("full count", count, 4);
    check("full flag", full, 1);
    check("full in_ready", in_if.ready, 0);

    // Fifth push is held while full.
    in_if.valid = 1'b1;
    in_if.data  = 8'h55;
    tick();
    tick();
    check("held count", count, 4);
    check("held in_ready", in_if.ready, 0);

    // Pop while full: pop goes, push refused, no bypass.
    out_if.ready = 1'b1;
    check("pop 11", out_if.data, 8'h11);
    tick();
    check("after full pop count", count, 3);
    check("after full pop in_ready", in_if.ready, 1);
    check("after full pop full", full, 0);
    check("pop 22", out_if.data, 8'h22);
    tick();
    check("push55+pop count", count, 3);
    in_if.valid = 1'b0;
    check("pop 33", out_if.data, 8'h33);
    tick();
    check("drain count 2", count, 2);
    check("pop 44", out_if.data, 8'h44);
    tick();
    check("pop 55", out_if.data, 8'h55);
    tick();
    check("drained empty", empty, 1);
    check("drained out_valid", out_if.valid, 0);

    // Streaming across pointer wrap, both sides ready.
    in_if.valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_if.data = 8'(i);
      tick();
      check("stream valid", out_if.valid, 1);
      check("stream data", out_if.data, 32'(i));
      check("stream count", count, 1);
    end
    in_if.valid = 1'b0;
    tick();
    check("stream end empty", empty, 1);
    out_if.ready = 1'b0;

    // Flush at count 3 with a push in the same cycle.
    push_one(8'hA0);
    push_one(8'hA1);
    push_one(8'hA2);
    check("pre-flush count", count, 3);
    flush       = 1'b1;
    in_if.valid = 1'b1;
    in_if.data  = 8'hA3;
    tick();
    flush       = 1'b0;
    in_if.valid = 1'b0;
    check("flush count", count, 0);
    check("flush empty", empty, 1);
    check("flush out_valid", out_if.valid, 0);
    check("flush in_ready", in_if.ready, 1);
    push_one(8'hB0);
    check("post-flush head", out_if.data, 8'hB0);
    check("post-flush count", count, 1);
    out_if.ready = 1'b1;
    tick();
    check("post-flush empty", empty, 1);
    out_if.ready = 1'b0;

    // Reset mid-operation with handshakes in the reset cycle.
    push_one(8'hC0);
    push_one(8'hC1);
    rst          = 1'b1;
    in_if.valid  = 1'b1;
    in_if.data   = 8'hC2;
    out_if.ready = 1'b1;
    tick();
    rst          = 1'b0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    check("mid-rst count", count, 0);
    check("mid-rst empty", empty, 1);
    check("mid-rst in_ready", in_if.ready, 0);
    tick();
    check("mid-rst release in_ready", in_if.ready, 1);
    check("mid-rst release count", count, 0);

    // Random traffic against a queue model.
    for (int c = 0; c < 1000; c++) begin
      logic do_push;
      logic do_pop;
      in_if.valid  = 1'($urandom_range(0, 1));
      in_if.data   = 8'($urandom);
      out_if.ready = 1'($urandom_range(0, 1));
      #1;
      check("rand in_ready", in_if.ready, (model_q.size() < DEPTH));
      check("rand out_valid", out_if.valid, (model_q.size() != 0));
      if (model_q.size() != 0) begin
        check("rand data", out_if.data, model_q[0]);
      end
      do_push = in_if.valid && (model_q.size() < DEPTH);
      do_pop  = out_if.ready && (model_q.size() != 0);
      tick();
      if (do_pop) begin
        void'(model_q.pop_front());
      end
      if (do_push) begin
        model_q.push_back(in_if.data);
      end
      check("rand count", count, model_q.size());
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hier_leaf_fifo.md
# hier_leaf_fifo

Synchronous first-word-fall-through FIFO that forms the leaf stage beneath each generated hierarchy instance. Its producer is a sibling leaf's output stream. Its consumer is the next sibling instance under the same parent. It decouples the valid/ready streams between adjacent instances, with bounded storage and occupancy reporting. There are no combinational paths from output handshake to input handshake.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- DEPTH, 4, number of storage entries; power of two, ≥2
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents; lower priority than rst
- in_valid  in  1  producer presents in_data
- in_ready  out  1  FIFO can accept this cycle
- in_data  in  DATA_W  write payload
- out_valid  out  1  out_data holds the oldest entry
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  DATA_W  head-of-queue payload
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Push occurs when in_valid && in_ready: in_data is written to mem[wr_ptr], and wr_ptr advances.
- Pop occurs when out_valid && out_ready: rd_ptr advances.
- in_ready = !full && !rst_q. It depends only on registered state, never on out_ready.
- out_valid = !empty. out_data = mem[rd_ptr], combinational read of registered storage.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
- count is updated per cycle:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- Full with out_ready=1: pop proceeds, push is refused because in_ready=0. Next cycle count=DEPTH-1 and in_ready=1. There is no bypass.
- Empty with push: the entry is not visible the same cycle. out_valid rises the next cycle.
- Flush: pointers and count go to 0 next cycle. Any push or pop in the flush cycle is discarded. Memory contents are not cleared.
- rst: same effect as flush. rst_q, a one-cycle registered copy of rst, holds in_ready low for the cycle after reset deasserts.
- Memory is not reset. out_data is unspecified whenever out_valid=0.
- Protocol assumption: the producer holds in_data stable while in_valid && !in_ready. The FIFO does not check this.

## Timing
- Reset values, with rst high and the first cycle after:
  - in_ready=0
  - out_valid=0
  - count=0
  - full=0
  - empty=1
- Latency, push to out_valid: 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained when 0<count<DEPTH.
- Reset mid-operation (rst sampled high): the next cycle is empty. In-flight handshakes in the rst cycle have no effect.
- flush and rst together: behave as rst.
- count, full, empty, in_ready and out_valid all change only on clk edges.

## Structure
- Shared package hier_leaf_pkg holds:
  - default constants LEAF_DATA_W=8, LEAF_DEPTH=4
  - function ptr_w(depth) returning $clog2(depth)
- Natural sub-module hier_leaf_ptr: wrapping pointer counter with parameter W and inputs clk, rst, clr, inc. It is instantiated twice (wr/rd).
- Storage is a flat register array in the top module; no RAM macro.
- Assertions in the top module:
  - never push when full
  - never pop when empty
  - count == (wr_ptr − rd_ptr) mod DEPTH, or DEPTH when full

## Test plan
- Reset, then idle 3 cycles → in_ready=0 for 1 cycle, then 1; empty=1, count=0, out_valid=0 throughout.
- Push 0x11,0x22,0x33,0x44 with out_ready=0, DEPTH=4:
  - full=1, count=4, in_ready=0
  - a 5th push of 0x55 is held until a pop
  - pops return 0x11,0x22,0x33,0x44,0x55 in order
- Full FIFO with simultaneous in_valid and out_ready:
  - pop 0x11 accepted, push refused
  - next cycle count=3, in_ready=1
- Streaming 16 incrementing bytes, both sides always ready:
  - 1-cycle latency, then one output per cycle
  - values 0x00..0x0F in order across pointer wrap
- Random out_ready/in_valid for 1000 cycles against a queue model → data order and count match every cycle.
- flush asserted at count=3 with a push the same cycle → next cycle count=0, empty=1, and the flushed data never appears.
